// File: rtl/sdram_arbiter.sv
// Three-requester round-robin arbiter in front of a single SDRAM controller.
// One transaction at a time: IDLE picks an owner, BUSY holds the controller
// strobes until it finishes (or the watchdog expires), DONE pulses the
// owner's completion for one cycle before the next grant.
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        req_read,
    input  logic [2:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr      [2:0],
    input  logic [DATA_W-1:0] req_writedata [2:0],
    output logic [DATA_W-1:0] req_readdata  [2:0],
    output logic [2:0]        req_finished,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_writedata,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_finished,
    output logic [1:0]        arb_grant,
    output logic              arb_busy,
    output logic              arb_timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    // Last BUSY cycle allowed before the watchdog aborts the transaction.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q [2:0];
    logic [DATA_W-1:0] rdata_d [2:0];
    logic [2:0]        fin_q, fin_d;
    logic              busy_q, busy_d;
    logic              to_q, to_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [2:0]        pend;
    logic              found;
    logic [1:0]        win;

    // Requester index 'step' places after 'base', modulo 3.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int step);
        int v;
        v = (int'(base) + step) % 3;
        return 2'(v);
    endfunction

    assign pend = req_read | req_write;

    // Round-robin search starting just after the previous owner, previous owner last.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int s = 1; s <= 3; s++) begin
            if (!found && pend[rr_idx(last_q, s)]) begin
                found = 1'b1;
                win   = rr_idx(last_q, s);
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fin_d   = 3'b000;
        busy_d  = busy_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BUSY;
                    last_d  = win;
                    grant_d = win;
                    // A simultaneous read+write request is served as a write.
                    wr_d    = req_write[win];
                    rd_d    = ~req_write[win];
                    addr_d  = req_addr[win];
                    wdata_d = req_writedata[win];
                    busy_d  = 1'b1;
                    cnt_d   = 16'd0;
                end
            end
            ST_BUSY: begin
                if (sdram_finished || cnt_q == CNT_LAST) begin
                    state_d        = ST_DONE;
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    fin_d[grant_q] = 1'b1;
                    // Completion wins over a coincident watchdog expiry.
                    if (sdram_finished) begin
                        if (rd_q) rdata_d[grant_q] = sdram_readdata;
                    end else begin
                        to_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers; last owner resets to 2 so requester 0 goes first.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_q  <= 2'd2;
            grant_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '{default: '0};
            fin_q   <= 3'b000;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            last_q  <= last_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_readdata    = rdata_q;
    assign req_finished    = fin_q;
    assign sdram_read      = rd_q;
    assign sdram_write     = wr_q;
    assign sdram_addr      = addr_q;
    assign sdram_writedata = wdata_q;
    assign arb_grant       = grant_q;
    assign arb_busy        = busy_q;
    assign arb_timeout     = to_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter. The reference model is transaction
// level: each grant becomes a record with a start cycle and an end cycle,
// and expected outputs for any cycle follow from where that cycle falls.
module tb_sdram_arbiter;
    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    rd, wr;
    logic [AW-1:0] addr [2:0];
    logic [DW-1:0] wd   [2:0];
    logic [DW-1:0] rdat [2:0];
    logic [2:0]    fin_o;
    logic          s_rd, s_wr, s_fin;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd, s_rdat;
    logic [1:0]    grant;
    logic          busy, tout;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .req_read(rd), .req_write(wr), .req_addr(addr), .req_writedata(wd),
        .req_readdata(rdat), .req_finished(fin_o),
        .sdram_read(s_rd), .sdram_write(s_wr), .sdram_addr(s_addr),
        .sdram_writedata(s_wd), .sdram_readdata(s_rdat), .sdram_finished(s_fin),
        .arb_grant(grant), .arb_busy(busy), .arb_timeout(tout)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Model state: current transaction record plus persistent arbiter facts.
    bit            tv;
    int            t_start, t_end, k_fin, rst_at, ntx;
    logic [1:0]    m_own, m_last, m_grant;
    bit            m_wr, m_to_ev, m_tflag, after_rst;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [DW-1:0] m_rdata [2:0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        tv      = 1'b0;
        m_last  = 2'd2;
        m_grant = 2'd0;
        m_addr  = '0;
        m_wd    = '0;
        m_tflag = 1'b0;
        rst_at  = -1;
        for (int i = 0; i < 3; i++) m_rdata[i] = '0;
    endtask

    task automatic check_cycle();
        bit busy_ph, done_ph;
        busy_ph = tv && cyc >= t_start && cyc <= t_end;
        done_ph = tv && cyc == t_end + 1;
        if (done_ph) begin
            if (m_to_ev)    m_tflag = 1'b1;
            else if (!m_wr) m_rdata[m_own] = m_rd;
        end
        chk("sdram_read",  s_rd, busy_ph && !m_wr);
        chk("sdram_write", s_wr, busy_ph && m_wr);
        if (busy_ph || after_rst) begin
            chk("sdram_addr",  s_addr, m_addr);
            chk("sdram_wdata", s_wd,   m_wd);
        end
        chk("req_finished", fin_o, done_ph ? (64'd1 << m_own) : 64'd0);
        chk("arb_busy",    busy,  busy_ph || done_ph);
        chk("arb_grant",   grant, m_grant);
        chk("arb_timeout", tout,  m_tflag);
        for (int i = 0; i < 3; i++)
            chk($sformatf("req_readdata%0d", i), rdat[i], m_rdata[i]);
    endtask

    task automatic drive_and_model();
        bit busy_ph, done_ph, idle_ph;
        int win;
        busy_ph   = tv && cyc >= t_start && cyc <= t_end;
        done_ph   = tv && cyc == t_end + 1;
        idle_ph   = !busy_ph && !done_ph;
        after_rst = 1'b0;

        // Requesters: owner drops on its completion pulse, idle ones may start.
        for (int i = 0; i < 3; i++) begin
            if (done_ph && m_own == 2'(i)) begin
                rd[i] = 1'b0;
                wr[i] = 1'b0;
            end else if (!(rd[i] | wr[i]) && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rd[i] = 1'b1;
                    1:       wr[i] = 1'b1;
                    default: begin rd[i] = 1'b1; wr[i] = 1'b1; end
                endcase
            end
            addr[i] = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
            wd[i]   = $urandom;
        end

        // Controller: completes on the planned BUSY cycle, otherwise noise outside BUSY.
        s_rdat = $urandom;
        if (busy_ph) begin
            s_fin = (cyc - t_start + 1 == k_fin);
            if (s_fin) m_rd = s_rdat;
        end else begin
            s_fin = ($urandom_range(0, 3) == 0);
        end

        if (tv && cyc == rst_at) begin
            rst_n = 1'b0;
            model_reset();
            after_rst = 1'b1;
        end else begin
            rst_n = 1'b1;
            if (idle_ph) begin
                win = -1;
                for (int s = 1; s <= 3; s++) begin
                    int idx = (int'(m_last) + s) % 3;
                    if (win < 0 && (rd[idx] | wr[idx])) win = idx;
                end
                if (win >= 0) begin
                    tv      = 1'b1;
                    m_own   = 2'(win);
                    m_last  = 2'(win);
                    m_grant = 2'(win);
                    m_wr    = wr[win];
                    m_addr  = addr[win];
                    m_wd    = wd[win];
                    t_start = cyc + 1;
                    k_fin   = $urandom_range(1, TO + 2);
                    m_to_ev = (k_fin > TO);
                    t_end   = m_to_ev ? cyc + TO : cyc + k_fin;
                    ntx++;
                    rst_at  = (k_fin >= 2 && ntx % 7 == 3) ? t_start + 1 : -1;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd    = 3'b000;
        wr    = 3'b000;
        s_fin = 1'b0;
        s_rdat = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        ntx = 0;
        model_reset();
        after_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        while (cyc < NCYC) begin
            check_cycle();
            drive_and_model();
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
